mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ws_allowin  in  1  writeback stage can accept an entry this cycle.
REQ-004 ms_allowin  out  1  MEM stage can accept an entry from EXE this cycle.
REQ-005 es_to_ms_valid  in  1  EXE presents a valid entry.
REQ-006 es_to_ms_bus  in  82  bits: [81:80] addr[1:0]; [79] mem_we; [78] ld_w; [77] ld_b; [76] ld_bu; [75] ld_h; [74] ld_hu; [73] st_w; [72] st_b; [71] st_h; [70] res_from_mem; [69] gr_we; [68:64] dest; [63:32] alu_result; [31:0] pc.
REQ-007 ms_to_ws_valid  out  1  MEM presents a completed entry to writeback.
REQ-008 ms_to_ws_bus  out  70  bits: [69] gr_we; [68:64] dest; [63:32] final_result; [31:0] pc.
REQ-009 data_sram_data_ok  in  1  one-cycle pulse; response for the oldest outstanding request.
REQ-010 data_sram_rdata  in  32  read data; valid only while data_ok=1.
REQ-011 ms_fwd_bus  out  39  bits: [38] fwd_valid; [37] data_pending; [36:32] dest; [31:0] final_result.

Function
REQ-012 Memory entry = latched mem_we | res_from_mem; every memory entry expects exactly one data_ok.
REQ-013 States: EMPTY, WAIT (memory entry without response), DONE (result available). ms_valid=0 in EMPTY, 1 otherwise.
REQ-014 Accept: es_to_ms_valid & ms_allowin latches es_to_ms_bus and goes to WAIT for a memory entry, DONE otherwise.
REQ-015 Accept with es_to_ms_valid=0 and ms_allowin=1 goes to EMPTY.
REQ-016 WAIT + data_ok goes to DONE and captures rdata into a 32-bit hold buffer.
REQ-017 ms_ready_go = (state==DONE) | (state==WAIT & data_ok).
REQ-018 ms_allowin = (state==EMPTY) | (ms_ready_go & ws_allowin).
REQ-019 ms_to_ws_valid = ms_valid & ms_ready_go.
REQ-020 Load data source is rdata when data_ok is high in WAIT, else the hold buffer (zero-latency bypass).
REQ-021 ld_w: full word. ld_b/ld_bu: byte addr[1:0], sign/zero extended. ld_h/ld_hu: halfword addr[1]*16, sign/zero extended.
REQ-022 final_result = extracted load data if res_from_mem, else alu_result; stores pass alu_result with gr_we as latched.
REQ-023 data_ok while EMPTY or DONE is a protocol error: ignored, no state change.
REQ-024 DONE with ws_allowin=0 holds the bus, buffer and outputs stable indefinitely.
REQ-025 Back-to-back: DONE/WAIT handoff plus new accept in the same cycle replaces the entry with no bubble.
REQ-026 Single outstanding request: ms_allowin=0 in WAIT without data_ok.

Reset
REQ-027 Reset forces EMPTY and clears hold buffer and latched bus to 0.
REQ-028 Reset gives ms_valid=0, ms_to_ws_valid=0, ms_allowin=1 and ms_fwd_bus=0 in the next cycle.
REQ-029 Reset has priority over accept and data_ok in the same cycle.
REQ-030 Reset mid-WAIT abandons the request; the memory system is reset by the same signal.

Configuration
REQ-031 Macro MS_FWD_EN defined: fwd_valid = ms_valid & gr_we; data_pending = (state==WAIT & res_from_mem & ~data_ok).
REQ-032 MS_FWD_EN defined: dest and final_result are driven as in REQ-022.
REQ-033 MS_FWD_EN undefined: ms_fwd_bus is tied to 0 and the decode stage stalls on MEM hazards.
REQ-034 All other behaviour is identical with and without MS_FWD_EN.

Verification
REQ-035 ALU entry (alu_result=0x1234, gr_we=1, dest=5), ws_allowin=1 -> ms_to_ws_valid next cycle, final_result=0x1234, no data_ok needed.
REQ-036 ld_b addr=2'b11, data_ok with rdata=0x80FF_0000 -> final_result=0xFFFF_FF80; ld_bu gives 0x0000_0080.
REQ-037 ld_h addr=2'b10, data_ok delayed 3 cycles with rdata=0x8001_xxxx -> ms_allowin=0 for 3 cycles, final_result=0xFFFF_8001.
REQ-038 data_ok=1 in WAIT while ws_allowin=0 for 4 cycles -> buffered value is held, then delivered exactly once when ws_allowin rises.
REQ-039 reset asserted in WAIT, then a spurious data_ok in EMPTY -> state EMPTY, outputs 0, no ms_to_ws_valid.
REQ-040 MS_FWD_EN on: load pending -> fwd_valid=1, data_pending=1; same case with MS_FWD_EN off -> ms_fwd_bus=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Pipeline handshake bundle around the MEM stage: EXE->MEM entry transfer
// and MEM->WB result transfer. The stage itself uses the slave modport.
interface mem_stage_if;
    logic        es_to_ms_valid;
    logic [81:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        ws_allowin;

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus
    );

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, extracts load data.
// Define MS_FWD_EN to drive the forwarding bus; otherwise it is tied to 0.
module mem_stage (
    input  logic          clk,
    input  logic          reset,
    mem_stage_if.slave    pipe,
    input  logic          data_sram_data_ok,
    input  logic [31:0]   data_sram_rdata,
    output logic [38:0]   ms_fwd_bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [81:0] ms_bus;
    logic [31:0] hold_buf;

    // Latched entry fields
    logic [1:0]  addr;
    logic        mem_we, ld_w, ld_b, ld_bu, ld_h, ld_hu, res_from_mem, gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result, pc;

    assign addr         = ms_bus[81:80];
    assign mem_we       = ms_bus[79];
    assign ld_w         = ms_bus[78];
    assign ld_b         = ms_bus[77];
    assign ld_bu        = ms_bus[76];
    assign ld_h         = ms_bus[75];
    assign ld_hu        = ms_bus[74];
    assign res_from_mem = ms_bus[70];
    assign gr_we        = ms_bus[69];
    assign dest         = ms_bus[68:64];
    assign alu_result   = ms_bus[63:32];
    assign pc           = ms_bus[31:0];

    // Store-width flags only matter to the request side in EXE.
    logic unused_st_flags;
    assign unused_st_flags = ^ms_bus[73:71];

    logic ms_valid, wait_ok, ms_ready_go, accept, mem_entry_in;

    assign ms_valid     = (state != S_EMPTY);
    // data_ok outside WAIT is a protocol error and is simply ignored.
    assign wait_ok      = (state == S_WAIT) && data_sram_data_ok;
    assign ms_ready_go  = (state == S_DONE) || wait_ok;
    assign pipe.ms_allowin     = (state == S_EMPTY) || (ms_ready_go && pipe.ws_allowin);
    assign pipe.ms_to_ws_valid = ms_valid && ms_ready_go;
    assign accept       = pipe.es_to_ms_valid && pipe.ms_allowin;
    assign mem_entry_in = pipe.es_to_ms_bus[79] || pipe.es_to_ms_bus[70];

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        if (pipe.ms_allowin) begin
            if (pipe.es_to_ms_valid) state_nxt = mem_entry_in ? S_WAIT : S_DONE;
            else                     state_nxt = S_EMPTY;
        end else if (wait_ok) begin
            state_nxt = S_DONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_EMPTY;
            ms_bus   <= '0;
            hold_buf <= '0;
        end else begin
            state <= state_nxt;
            if (accept)  ms_bus   <= pipe.es_to_ms_bus;
            if (wait_ok) hold_buf <= data_sram_rdata;
        end
    end

    // Zero-latency bypass: the response is usable in the cycle it arrives.
    logic [31:0] ld_src, ld_res, final_result;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_src  = wait_ok ? data_sram_rdata : hold_buf;
    assign ld_half = addr[1] ? ld_src[31:16] : ld_src[15:0];

    always_comb begin
        ld_byte = ld_src[7:0];
        case (addr)
            2'd0: ld_byte = ld_src[7:0];
            2'd1: ld_byte = ld_src[15:8];
            2'd2: ld_byte = ld_src[23:16];
            2'd3: ld_byte = ld_src[31:24];
            default: ld_byte = ld_src[7:0];
        endcase
    end

    always_comb begin
        ld_res = ld_src;
        if      (ld_w)  ld_res = ld_src;
        else if (ld_b)  ld_res = {{24{ld_byte[7]}}, ld_byte};
        else if (ld_bu) ld_res = {24'd0, ld_byte};
        else if (ld_h)  ld_res = {{16{ld_half[15]}}, ld_half};
        else if (ld_hu) ld_res = {16'd0, ld_half};
    end

    assign final_result      = res_from_mem ? ld_res : alu_result;
    assign pipe.ms_to_ws_bus = {gr_we, dest, final_result, pc};

`ifdef MS_FWD_EN
    logic fwd_valid, data_pending;
    logic unused_mem_we;
    assign unused_mem_we = mem_we;
    assign fwd_valid    = ms_valid && gr_we;
    assign data_pending = (state == S_WAIT) && res_from_mem && !data_sram_data_ok;
    assign ms_fwd_bus   = {fwd_valid, data_pending, dest, final_result};
`else
    // Without forwarding the decode stage stalls on any MEM hazard.
    logic unused_fwd;
    assign unused_fwd = mem_we;
    assign ms_fwd_bus = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expectations are hand-computed.
// Forwarding expectations follow whether MS_FWD_EN is defined for the build.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [38:0] ms_fwd_bus;

    int checks   = 0;
    int failures = 0;

    mem_stage_if pipe ();

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .pipe              (pipe.slave),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    always #5 clk = ~clk;

    // flags = {mem_we, ld_w, ld_b, ld_bu, ld_h, ld_hu, st_w, st_b, st_h, res_from_mem, gr_we}
    localparam logic [10:0] F_ALU  = 11'b0_0_0_0_0_0_0_0_0_0_1;
    localparam logic [10:0] F_LDW  = 11'b0_1_0_0_0_0_0_0_0_1_1;
    localparam logic [10:0] F_LDB  = 11'b0_0_1_0_0_0_0_0_0_1_1;
    localparam logic [10:0] F_LDBU = 11'b0_0_0_1_0_0_0_0_0_1_1;
    localparam logic [10:0] F_LDH  = 11'b0_0_0_0_1_0_0_0_0_1_1;
    localparam logic [10:0] F_LDHU = 11'b0_0_0_0_0_1_0_0_0_1_1;
    localparam logic [10:0] F_STW  = 11'b1_0_0_0_0_0_1_0_0_0_0;

    function automatic logic [81:0] make_bus(input logic [1:0] a, input logic [10:0] f,
                                             input logic [4:0] d, input logic [31:0] alu,
                                             input logic [31:0] pc);
        return {a, f, d, alu, pc};
    endfunction

    task automatic check(input string tag, input logic [81:0] obs, input logic [81:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic [81:0] b);
        pipe.es_to_ms_valid = 1'b1;
        pipe.es_to_ms_bus   = b;
    endtask

    task automatic idle();
        pipe.es_to_ms_valid = 1'b0;
        data_sram_data_ok   = 1'b0;
    endtask

    task automatic check_fwd_pending(input string tag, input logic [4:0] d);
`ifdef MS_FWD_EN
        check(tag, ms_fwd_bus[38:32], {1'b1, 1'b1, d});
`else
        check(tag, ms_fwd_bus, 39'd0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        pipe.es_to_ms_valid = 1'b0;
        pipe.es_to_ms_bus   = '0;
        pipe.ws_allowin     = 1'b1;
        data_sram_data_ok   = 1'b0;
        data_sram_rdata     = '0;
        tick(); tick();
        reset = 1'b0;
        settle();
        check("rst_allowin", pipe.ms_allowin, 1'b1);
        check("rst_valid",   pipe.ms_to_ws_valid, 1'b0);
        check("rst_fwd",     ms_fwd_bus, 39'd0);
        check("rst_bus",     pipe.ms_to_ws_bus, 70'd0);

        // ALU entry: result next cycle, no data_ok needed
        present(make_bus(2'd0, F_ALU, 5'd5, 32'h1234, 32'h1c00_0000));
        tick(); idle(); settle();
        check("alu_valid", pipe.ms_to_ws_valid, 1'b1);
        check("alu_bus",   pipe.ms_to_ws_bus, {1'b1, 5'd5, 32'h1234, 32'h1c00_0000});
        tick(); settle();
        check("alu_drain", pipe.ms_to_ws_valid, 1'b0);

        // ld_b addr 3, sign extended
        present(make_bus(2'd3, F_LDB, 5'd7, 32'h2003, 32'h1c00_0004));
        tick(); idle(); settle();
        check("ldb_wait_allowin", pipe.ms_allowin, 1'b0);
        check("ldb_wait_valid",   pipe.ms_to_ws_valid, 1'b0);
        check_fwd_pending("ldb_fwd_pending", 5'd7);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000; settle();
        check("ldb_ok_valid",   pipe.ms_to_ws_valid, 1'b1);
        check("ldb_ok_allowin", pipe.ms_allowin, 1'b1);
        check("ldb_result",     pipe.ms_to_ws_bus[63:32], 32'hFFFF_FF80);
        tick(); idle(); settle();
        check("ldb_drain", pipe.ms_to_ws_valid, 1'b0);

        // ld_bu same address and data, zero extended
        present(make_bus(2'd3, F_LDBU, 5'd8, 32'h2003, 32'h1c00_0008));
        tick(); idle();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000; settle();
        check("ldbu_result", pipe.ms_to_ws_bus[63:32], 32'h0000_0080);
        tick(); idle();

        // ld_h addr 2, response 3 cycles late, then back-to-back ALU entry
        present(make_bus(2'd2, F_LDH, 5'd9, 32'h3002, 32'h1c00_000c));
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("ldh_stall%0d", i), pipe.ms_allowin, 1'b0);
            tick();
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_5A5A;
        present(make_bus(2'd0, F_ALU, 5'd10, 32'hCAFE_0001, 32'h1c00_0010));
        settle();
        check("ldh_result",  pipe.ms_to_ws_bus, {1'b1, 5'd9, 32'hFFFF_8001, 32'h1c00_000c});
        check("b2b_allowin", pipe.ms_allowin, 1'b1);
        tick(); idle(); settle();
        check("b2b_valid", pipe.ms_to_ws_valid, 1'b1);
        check("b2b_bus",   pipe.ms_to_ws_bus, {1'b1, 5'd10, 32'hCAFE_0001, 32'h1c00_0010});
        tick(); settle();

        // ld_hu addr 0, zero extended low half
        present(make_bus(2'd0, F_LDHU, 5'd11, 32'h4000, 32'h1c00_0014));
        tick(); idle();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_F00D; settle();
        check("ldhu_result", pipe.ms_to_ws_bus[63:32], 32'h0000_F00D);
        tick(); idle();

        // ld_w answered while WB is blocked: held for 4 cycles, delivered once
        present(make_bus(2'd0, F_LDW, 5'd12, 32'h5000, 32'h1c00_0018));
        tick(); idle();
        pipe.ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("hold_valid%0d", i), pipe.ms_to_ws_valid, 1'b1);
            check($sformatf("hold_bus%0d", i), pipe.ms_to_ws_bus,
                  {1'b1, 5'd12, 32'hDEAD_BEEF, 32'h1c00_0018});
            tick();
            data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0BAD_0BAD;
        end
        pipe.ws_allowin = 1'b1; settle();
        check("hold_release_allowin", pipe.ms_allowin, 1'b1);
        tick(); settle();
        check("hold_once", pipe.ms_to_ws_valid, 1'b0);

        // Store: alu_result passes through, gr_we stays 0
        present(make_bus(2'd0, F_STW, 5'd0, 32'h0000_0100, 32'h1c00_001c));
        tick(); idle(); settle();
        check("st_wait", pipe.ms_to_ws_valid, 1'b0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF; settle();
        check("st_bus", pipe.ms_to_ws_bus, {1'b0, 5'd0, 32'h0000_0100, 32'h1c00_001c});
        tick(); idle();

        // Spurious data_ok in EMPTY is ignored
        data_sram_data_ok = 1'b1; settle();
        check("spur_empty_valid", pipe.ms_to_ws_valid, 1'b0);
        tick(); idle(); settle();
        check("spur_empty_after", pipe.ms_to_ws_valid, 1'b0);

        // Spurious data_ok in DONE with WB blocked leaves the entry untouched
        present(make_bus(2'd0, F_ALU, 5'd13, 32'h7777_0000, 32'h1c00_0020));
        tick(); idle();
        pipe.ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_2222;
        tick(); data_sram_data_ok = 1'b0; settle();
        check("spur_done_bus", pipe.ms_to_ws_bus, {1'b1, 5'd13, 32'h7777_0000, 32'h1c00_0020});
        pipe.ws_allowin = 1'b1;
        tick(); settle();

        // Reset mid-WAIT beats accept and data_ok; later data_ok is spurious
        present(make_bus(2'd0, F_LDW, 5'd14, 32'h6000, 32'h1c00_0024));
        tick();
        reset = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_AAAA;
        present(make_bus(2'd0, F_ALU, 5'd15, 32'h9999, 32'h1c00_0028));
        tick();
        reset = 1'b0; pipe.es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; settle();
        check("rstw_valid",   pipe.ms_to_ws_valid, 1'b0);
        check("rstw_allowin", pipe.ms_allowin, 1'b1);
        check("rstw_bus",     pipe.ms_to_ws_bus, 70'd0);
        check("rstw_fwd",     ms_fwd_bus, 39'd0);
        tick(); idle(); settle();
        check("rstw_after", pipe.ms_to_ws_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
